// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: two producers share the register file's single write port
// through a round-robin grant and a registered write stage. Optional forwarding: WB_FWD_EN.
module regfile_wb_arbiter #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 64,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              src0_valid,
   input  logic [ADDR_W-1:0] src0_addr,
   input  logic [DATA_W-1:0] src0_data,
   output logic              src0_ready,
   input  logic              src1_valid,
   input  logic [ADDR_W-1:0] src1_addr,
   input  logic [DATA_W-1:0] src1_data,
   output logic              src1_ready,
   output logic              RegWrite,
   output logic [ADDR_W-1:0] write_reg_addr,
   output logic [DATA_W-1:0] write_reg_data,
   output logic [CNT_W-1:0]  conflict_cnt
`ifdef WB_FWD_EN
   ,
   input  logic [ADDR_W-1:0] read_reg_addr_1,
   input  logic [ADDR_W-1:0] read_reg_addr_2,
   output logic              fwd_hit_1,
   output logic              fwd_hit_2,
   output logic [DATA_W-1:0] fwd_data_1,
   output logic [DATA_W-1:0] fwd_data_2
`endif
);

   typedef enum logic {
      SRC0 = 1'b0,
      SRC1 = 1'b1
   } src_e;

   src_e              last_grant;
   logic              grant0;
   logic              grant1;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;
   logic              contended;

   assign contended = src0_valid & src1_valid;

   // Under contention the source that did not win last time is served.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (!reset) begin
         if (contended) begin
            if (last_grant == SRC1) grant0 = 1'b1;
            else                    grant1 = 1'b1;
         end else begin
            grant0 = src0_valid;
            grant1 = src1_valid;
         end
      end
   end

   always_comb begin
      sel_addr = src0_addr;
      sel_data = src0_data;
      if (grant1) begin
         sel_addr = src1_addr;
         sel_data = src1_data;
      end
   end

   assign src0_ready = grant0;
   assign src1_ready = grant1;

   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant     <= SRC1;
         RegWrite       <= 1'b0;
         write_reg_addr <= '0;
         write_reg_data <= '0;
         conflict_cnt   <= '0;
      end else begin
         if (grant0 || grant1) begin
            // x0 requests complete the handshake but never enable the write.
            RegWrite       <= (sel_addr != '0);
            write_reg_addr <= sel_addr;
            write_reg_data <= sel_data;
            last_grant     <= grant1 ? SRC1 : SRC0;
         end else begin
            RegWrite <= 1'b0;
         end
         if (contended && (conflict_cnt != '1))
            conflict_cnt <= conflict_cnt + 1'b1;
      end
   end

`ifdef WB_FWD_EN
   always_comb begin
      fwd_hit_1  = RegWrite && (write_reg_addr == read_reg_addr_1) && (read_reg_addr_1 != '0);
      fwd_hit_2  = RegWrite && (write_reg_addr == read_reg_addr_2) && (read_reg_addr_2 != '0);
      fwd_data_1 = fwd_hit_1 ? write_reg_data : '0;
      fwd_data_2 = fwd_hit_2 ? write_reg_data : '0;
   end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: stimulus queues expected register-file
// writes, a negedge monitor checks every cycle of the write port against the queue.
module tb_regfile_wb_arbiter;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 64;
   localparam int CNT_W  = 4;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              src0_valid = 1'b0;
   logic [ADDR_W-1:0] src0_addr = '0;
   logic [DATA_W-1:0] src0_data = '0;
   logic              src0_ready;
   logic              src1_valid = 1'b0;
   logic [ADDR_W-1:0] src1_addr = '0;
   logic [DATA_W-1:0] src1_data = '0;
   logic              src1_ready;
   logic              RegWrite;
   logic [ADDR_W-1:0] write_reg_addr;
   logic [DATA_W-1:0] write_reg_data;
   logic [CNT_W-1:0]  conflict_cnt;
`ifdef WB_FWD_EN
   logic [ADDR_W-1:0] read_reg_addr_1 = 5'd5;
   logic [ADDR_W-1:0] read_reg_addr_2 = 5'd0;
   logic              fwd_hit_1;
   logic              fwd_hit_2;
   logic [DATA_W-1:0] fwd_data_1;
   logic [DATA_W-1:0] fwd_data_2;
`endif

   regfile_wb_arbiter #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W),
      .CNT_W (CNT_W)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .src0_valid     (src0_valid),
      .src0_addr      (src0_addr),
      .src0_data      (src0_data),
      .src0_ready     (src0_ready),
      .src1_valid     (src1_valid),
      .src1_addr      (src1_addr),
      .src1_data      (src1_data),
      .src1_ready     (src1_ready),
      .RegWrite       (RegWrite),
      .write_reg_addr (write_reg_addr),
      .write_reg_data (write_reg_data),
      .conflict_cnt   (conflict_cnt)
`ifdef WB_FWD_EN
      ,
      .read_reg_addr_1(read_reg_addr_1),
      .read_reg_addr_2(read_reg_addr_2),
      .fwd_hit_1      (fwd_hit_1),
      .fwd_hit_2      (fwd_hit_2),
      .fwd_data_1     (fwd_data_1),
      .fwd_data_2     (fwd_data_2)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned       due;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_t;

   wr_t         exp_q[$];
   int unsigned cyc = 0;
   int          checks = 0;
   int          failures = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=%h expected=%h", nm, cyc, act, exp);
      end
   endtask

   // Monitor: every cycle the write port either matches the due entry or is idle.
   always @(negedge clk) begin
      wr_t e;
      while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
         e = exp_q.pop_front();
         chk("wb_missed", 64'(e.due), 64'(cyc));
      end
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
         e = exp_q.pop_front();
         chk("wb_en",   64'(RegWrite), 64'd1);
         chk("wb_addr", 64'(write_reg_addr), 64'(e.addr));
         chk("wb_data", 64'(write_reg_data), 64'(e.data));
      end else begin
         chk("wb_idle", 64'(RegWrite), 64'd0);
      end
   end

   // One cycle: apply inputs after the edge, check grants at negedge, queue writes.
   task automatic step(input logic rst,
                       input logic v0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                       input logic v1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1,
                       input logic eg0, input logic eg1);
      wr_t e;
      @(posedge clk);
      #1;
      reset = rst;
      src0_valid = v0; src0_addr = a0; src0_data = d0;
      src1_valid = v1; src1_addr = a1; src1_data = d1;
      @(negedge clk);
      chk("src0_ready", 64'(src0_ready), 64'(eg0));
      chk("src1_ready", 64'(src1_ready), 64'(eg1));
      if (eg0 && a0 != '0) begin
         e.due = cyc + 1; e.addr = a0; e.data = d0;
         exp_q.push_back(e);
      end
      if (eg1 && a1 != '0) begin
         e.due = cyc + 1; e.addr = a1; e.data = d1;
         exp_q.push_back(e);
      end
   endtask

   task automatic idle();
      step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
   endtask

   localparam logic [DATA_W-1:0] DA = 64'hAAAA_0000_0000_000A;
   localparam logic [DATA_W-1:0] DB = 64'hBBBB_0000_0000_000B;

   initial begin
      // Reset with both sources requesting: no grants, outputs cleared.
      for (int i = 0; i < 2; i++)
         step(1'b1, 1'b1, 5'd3, DA, 1'b1, 5'd4, DB, 1'b0, 1'b0);
      chk("rst_cnt",  64'(conflict_cnt), 64'd0);
      chk("rst_addr", 64'(write_reg_addr), 64'd0);
      chk("rst_data", 64'(write_reg_data), 64'd0);

      // Contention from reset: grants 0,1,0,1.
      for (int i = 0; i < 4; i++)
         step(1'b0, 1'b1, 5'd3, DA, 1'b1, 5'd4, DB, (i % 2) == 0, (i % 2) == 1);
      idle();
      chk("cnt_after_4", 64'(conflict_cnt), 64'd4);

      // Single request on source 0.
      step(1'b0, 1'b1, 5'd5, 64'h1234, 1'b0, '0, '0, 1'b1, 1'b0);
      idle();
      idle();

      // x0 request on source 1: handshakes, no write, last_grant becomes 1.
      step(1'b0, 1'b0, '0, '0, 1'b1, 5'd0, 64'h5555, 1'b0, 1'b1);
      idle();

      // Same address: source 0 first (last_grant=1), loser writes next cycle.
      step(1'b0, 1'b1, 5'd7, 64'h11, 1'b1, 5'd7, 64'h22, 1'b1, 1'b0);
      step(1'b0, 1'b0, '0, '0, 1'b1, 5'd7, 64'h22, 1'b0, 1'b1);
      idle();
      chk("cnt_after_same", 64'(conflict_cnt), 64'd5);

      // Forwarding window: read port 1 watches addr 5, read port 2 watches x0.
      step(1'b0, 1'b1, 5'd5, 64'hABCD, 1'b0, '0, '0, 1'b1, 1'b0);
`ifdef WB_FWD_EN
      chk("fwd_hit1_idle", 64'(fwd_hit_1), 64'd0);
`endif
      idle();
`ifdef WB_FWD_EN
      chk("fwd_hit1",  64'(fwd_hit_1), 64'd1);
      chk("fwd_data1", fwd_data_1, 64'hABCD);
      chk("fwd_hit2",  64'(fwd_hit_2), 64'd0);
      chk("fwd_data2", fwd_data_2, 64'd0);
`endif

      // Reset while the addr 9 write sits in the output register.
      step(1'b0, 1'b1, 5'd9, 64'h99, 1'b0, '0, '0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 5'd1, 64'h100, 1'b1, 5'd2, 64'h200, 1'b0, 1'b0);
      step(1'b1, 1'b1, 5'd1, 64'h100, 1'b1, 5'd2, 64'h200, 1'b0, 1'b0);
      chk("midrst_cnt", 64'(conflict_cnt), 64'd0);

      // Continuous contention after release: source 0 first, then alternate; counter saturates.
      for (int k = 1; k <= 19; k++) begin
         step(1'b0, 1'b1, 5'd1, 64'h100, 1'b1, 5'd2, 64'h200, (k % 2) == 1, (k % 2) == 0);
         if (k == 15) chk("cnt_pre_sat", 64'(conflict_cnt), 64'd14);
         if (k == 16) chk("cnt_sat",     64'(conflict_cnt), 64'd15);
      end
      idle();
      chk("cnt_held_sat", 64'(conflict_cnt), 64'd15);
      idle();
      idle();
      chk("queue_drained", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog cycle=%0d actual=timeout expected=finish", cyc);
      $fatal(1);
   end

endmodule
